// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin arbiter and transaction sequencer that lets
// NUM_REQ requesters share one SPI master. Completion is taken from the
// master's slave-select line, and a per-transfer timeout releases the bus if a
// frame never finishes.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | bus free; req sampled, round-robin winner latched
// S_LAUNCH    | starts asserted for the first cycle, timeout counter cleared
// S_WAIT_LOW  | starts held; waiting for ss to fall (frame begun)
// S_WAIT_HIGH | starts held; waiting for ss to rise (frame finished)
// S_RESP      | one-cycle rsp_valid pulse to the granted requester
// S_GAP       | starts and grant low for GAP_CYCLES before returning to idle
module spi_xfer_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int XFER_TO    = 256,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_rx,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    output logic                        busy,
    output logic                        m_start_tx,
    output logic                        m_start_rx,
    output logic [DATA_W-1:0]           m_data_tx,
    input  logic [DATA_W-1:0]           m_data_rx,
    input  logic                        m_ss
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(XFER_TO + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_RESP,
        S_GAP
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 rx_sel;
    logic [CNT_W-1:0]     xfer_cnt;
    logic [GAP_W-1:0]     gap_cnt;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_rx;

    logic                 in_wait;
    logic                 frame_done;
    logic                 xfer_abort;
    logic                 gap_done;
    logic                 starts_on;

    // A normal end of frame wins over a timeout landing in the same cycle.
    assign in_wait    = (state == S_WAIT_LOW) || (state == S_WAIT_HIGH);
    assign frame_done = (state == S_WAIT_HIGH) && m_ss;
    assign xfer_abort = in_wait && !frame_done && (xfer_cnt == CNT_W'(XFER_TO - 1));
    assign gap_done   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // Round-robin pick: first set req bit scanning upward from rr_ptr.
    always_comb begin
        int k;
        k         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!sel_found && req[k]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k);
            end
        end
    end

    // Steer the winner's one-hot grant, TX byte and RX-enable bit.
    always_comb begin
        sel_onehot = '0;
        sel_data   = '0;
        sel_rx     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_onehot[i] = sel_found;
                sel_data      = req_data[i*DATA_W +: DATA_W];
                sel_rx        = req_rx[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (sel_found) state_nxt = S_LAUNCH;
            S_LAUNCH:    state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (xfer_abort) begin
                    state_nxt = S_RESP;
                end else if (!m_ss) begin
                    state_nxt = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: if (frame_done || xfer_abort) state_nxt = S_RESP;
            S_RESP:      state_nxt = S_GAP;
            S_GAP:       if (gap_done) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; starts are level, held LAUNCH through WAIT_HIGH.
    always_comb begin
        starts_on  = (state == S_LAUNCH) || in_wait;
        busy       = (state != S_IDLE);
        m_start_tx = starts_on;
        m_start_rx = starts_on && rx_sel;
        rsp_valid  = (state == S_RESP) ? gnt : '0;
    end

    // Grant, transfer data, counters and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            rx_sel    <= 1'b0;
            m_data_tx <= '0;
            xfer_cnt  <= '0;
            gap_cnt   <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        gnt       <= sel_onehot;
                        gnt_idx   <= sel_idx;
                        m_data_tx <= sel_data;
                        rx_sel    <= sel_rx;
                    end
                end
                S_LAUNCH: begin
                    xfer_cnt <= '0;
                end
                S_WAIT_LOW, S_WAIT_HIGH: begin
                    xfer_cnt <= xfer_cnt + 1'b1;
                    if (frame_done) begin
                        rsp_data <= rx_sel ? m_data_rx : '0;
                        rsp_err  <= 1'b0;
                    end else if (xfer_abort) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                S_RESP: begin
                    gnt     <= '0;
                    gap_cnt <= '0;
                    rr_ptr  <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                    gnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter. A small behavioural SPI master model
// answers the starts by pulling ss low for a few cycles and presenting a
// slave byte on m_data_rx when ss rises.
module tb_spi_xfer_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_W     = 8;
    localparam int XFER_TO    = 256;
    localparam int GAP_CYCLES = 2;
    localparam int WAIT_MAX   = 600;

    logic                       clk;
    logic                       rst;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         req_rx;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [DATA_W-1:0]          rsp_data;
    logic                       rsp_err;
    logic                       busy;
    logic                       m_start_tx;
    logic                       m_start_rx;
    logic [DATA_W-1:0]          m_data_tx;
    logic [DATA_W-1:0]          m_data_rx;
    logic                       m_ss;

    int n_cmp;
    int n_bad;

    // master model controls and observations
    logic                       ss_stuck;
    int                         ss_len;
    logic [DATA_W-1:0]          slave_tx;
    logic [DATA_W-1:0]          slave_rx;
    logic                       rx_lost;

    spi_xfer_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .XFER_TO    (XFER_TO),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_rx     (req_rx),
        .req_data   (req_data),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .m_start_tx (m_start_tx),
        .m_start_rx (m_start_rx),
        .m_data_tx  (m_data_tx),
        .m_data_rx  (m_data_rx),
        .m_ss       (m_ss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SPI master: ss falls one cycle after the starts are seen,
    // stays low ss_len cycles, then rises with the slave byte on m_data_rx.
    initial begin
        m_ss      = 1'b1;
        m_data_rx = '0;
        slave_rx  = '0;
        rx_lost   = 1'b0;
        forever begin
            @(negedge clk);
            if (ss_stuck) begin
                m_data_rx = slave_tx;
            end
            if (m_start_tx === 1'b1 && !ss_stuck) begin
                rx_lost = (m_start_rx !== 1'b1);
                @(negedge clk);
                if (m_start_rx !== 1'b1) rx_lost = 1'b1;
                m_ss     = 1'b0;
                slave_rx = m_data_tx;
                for (int i = 0; i < ss_len; i++) begin
                    @(negedge clk);
                    if (m_start_rx !== 1'b1) rx_lost = 1'b1;
                end
                m_data_rx = slave_tx;
                m_ss      = 1'b1;
                for (int i = 0; i < 20 && m_start_tx === 1'b1; i++) begin
                    @(negedge clk);
                end
            end
        end
    end

    task automatic wait_gnt(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (gnt !== '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (rsp_valid !== '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        req      = '0;
        req_rx   = '0;
        req_data = '0;
        ss_stuck = 1'b0;
        ss_len   = 3;
        slave_tx = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL reset_rsp_data: got %h expected 00", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if ({m_start_tx, m_start_rx} !== 2'b00) begin n_bad++; $display("FAIL reset_starts: got %b expected 00", {m_start_tx, m_start_rx}); end
        n_cmp++; if (m_data_tx !== 8'h00) begin n_bad++; $display("FAIL reset_data_tx: got %h expected 00", m_data_tx); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_tx_only();
        logic ok;
        req            = 4'b0001;
        req_rx         = 4'b0000;
        req_data[7:0]  = 8'hAA;
        slave_tx       = 8'h3C;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL tx_gnt: got %b expected 0001", gnt); end
        req_data[7:0] = 8'h55;
        wait_rsp(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL tx_rsp_wait: got no rsp_valid expected a pulse"); end
        n_cmp++; if (rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL tx_rsp_valid: got %b expected 0001", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL tx_rsp_err: got %b expected 0", rsp_err); end
        n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL tx_rsp_data: got %h expected 00", rsp_data); end
        n_cmp++; if (slave_rx !== 8'hAA) begin n_bad++; $display("FAIL tx_slave_rx: got %h expected aa", slave_rx); end
        req = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL tx_rsp_one_cycle: got %b expected 0000", rsp_valid); end
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL tx_gnt_clear: got %b expected 0000", gnt); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rx();
        logic ok;
        req             = 4'b0010;
        req_rx          = 4'b0010;
        req_data[15:8]  = 8'h12;
        slave_tx        = 8'hFF;
        wait_rsp(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rx_rsp_wait: got no rsp_valid expected a pulse"); end
        n_cmp++; if (rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL rx_rsp_valid: got %b expected 0010", rsp_valid); end
        n_cmp++; if (rsp_data !== 8'hFF) begin n_bad++; $display("FAIL rx_rsp_data: got %h expected ff", rsp_data); end
        n_cmp++; if (rx_lost !== 1'b0) begin n_bad++; $display("FAIL rx_start_rx_held: got dropped=%b expected 0", rx_lost); end
        req    = '0;
        req_rx = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic ok;
        int   n;
        int   exp_idx [6];
        exp_idx = '{0, 1, 3, 0, 1, 3};
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        req      = 4'b1011;
        slave_tx = 8'h00;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(ok);
            n_cmp++; if (gnt !== (4'b0001 << exp_idx[k])) begin n_bad++; $display("FAIL rr_gnt%0d: got %b expected %b", k, gnt, 4'b0001 << exp_idx[k]); end
            wait_rsp(ok);
            n_cmp++; if (rsp_valid !== (4'b0001 << exp_idx[k])) begin n_bad++; $display("FAIL rr_rsp%0d: got %b expected %b", k, rsp_valid, 4'b0001 << exp_idx[k]); end
            if (k == 5) begin
                req = '0;
            end else begin
                // GAP_CYCLES gap cycles plus the IDLE sampling cycle
                n = 0;
                @(negedge clk);
                while (gnt === '0 && n < 50) begin
                    n++;
                    @(negedge clk);
                end
                n_cmp++; if (n != GAP_CYCLES + 1) begin n_bad++; $display("FAIL rr_gap%0d: got %0d idle cycles expected %0d", k, n, GAP_CYCLES + 1); end
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic ok;
        int   n;
        ss_stuck = 1'b1;
        slave_tx = 8'h5A;
        req_rx   = 4'b0100;
        req      = 4'b0100;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_start_tx === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_launch: got no start expected start_tx"); end
        // LAUNCH cycle itself plus XFER_TO counted wait cycles
        n = 0;
        while (rsp_valid === '0 && n < XFER_TO + 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (n != XFER_TO + 1) begin n_bad++; $display("FAIL to_latency: got %0d cycles expected %0d", n, XFER_TO + 1); end
        n_cmp++; if (rsp_valid !== 4'b0100) begin n_bad++; $display("FAIL to_rsp_valid: got %b expected 0100", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL to_rsp_err: got %b expected 1", rsp_err); end
        n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL to_rsp_data: got %h expected 00", rsp_data); end
        n_cmp++; if ({m_start_tx, m_start_rx} !== 2'b00) begin n_bad++; $display("FAIL to_starts: got %b expected 00", {m_start_tx, m_start_rx}); end
        req    = '0;
        req_rx = '0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL to_busy_gap: got %b expected 1", busy); end
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_busy_idle: got %b expected 0", busy); end
        ss_stuck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic ok;
        int   n;
        ss_len        = 10;
        slave_tx      = 8'hC3;
        req_data[7:0] = 8'h81;
        req_rx        = 4'b0001;
        req           = 4'b0001;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_ss === 1'b0) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        n_cmp++; if (!ok || m_start_tx !== 1'b1) begin n_bad++; $display("FAIL rm_in_frame: got ss_seen=%b start=%b expected 1 1", ok, m_start_tx); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if ({gnt, rsp_valid} !== 8'h00) begin n_bad++; $display("FAIL rm_gnt_rsp: got %b expected 00000000", {gnt, rsp_valid}); end
        n_cmp++; if ({busy, m_start_tx, m_start_rx, rsp_err} !== 4'b0000) begin n_bad++; $display("FAIL rm_ctrl: got %b expected 0000", {busy, m_start_tx, m_start_rx, rsp_err}); end
        n_cmp++; if ({m_data_tx, rsp_data} !== 16'h0000) begin n_bad++; $display("FAIL rm_data: got %h expected 0000", {m_data_tx, rsp_data}); end
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid !== '0) n++;
        end
        n_cmp++; if (n != 0) begin n_bad++; $display("FAIL rm_no_rsp: got %0d pulses expected 0", n); end
        rst    = 1'b1;
        ss_len = 3;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rm_regrant: got %b expected 0001", gnt); end
        wait_rsp(ok);
        n_cmp++; if (rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL rm_rsp_valid: got %b expected 0001", rsp_valid); end
        n_cmp++; if ({rsp_err, rsp_data} !== {1'b0, 8'hC3}) begin n_bad++; $display("FAIL rm_rsp: got err=%b data=%h expected 0 c3", rsp_err, rsp_data); end
        req    = '0;
        req_rx = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_req_drop();
        logic ok;
        // rr_ptr is 1 after the previous grant to requester 0
        req_data[23:16] = 8'h77;
        req_data[31:24] = 8'h99;
        req             = 4'b1101;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL rd_gnt: got %b expected 0100", gnt); end
        @(negedge clk);
        req = 4'b1001;
        wait_rsp(ok);
        n_cmp++; if (rsp_valid !== 4'b0100) begin n_bad++; $display("FAIL rd_rsp_valid: got %b expected 0100", rsp_valid); end
        n_cmp++; if (slave_rx !== 8'h77) begin n_bad++; $display("FAIL rd_slave_rx: got %h expected 77", slave_rx); end
        @(negedge clk);
        wait_gnt(ok);
        n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL rd_next_gnt: got %b expected 1000", gnt); end
        n_cmp++; if (m_data_tx !== 8'h99) begin n_bad++; $display("FAIL rd_next_data: got %h expected 99", m_data_tx); end
        req = '0;
        wait_rsp(ok);
        n_cmp++; if (rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL rd_next_rsp: got %b expected 1000", rsp_valid); end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_tx_only();
        test_rx();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_req_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
